serial_rx: RTL

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 28 ++
 rtl/serial_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit blocks: default line rates and the
// receiver state encoding.
package serial_pkg;

    localparam int unsigned DefClkHz = 54_000_000;
    localparam int unsigned DefBaud  = 9600;
    localparam int unsigned DefOvs   = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, shared by the receiver
// and transmitter.
module baud_tick_gen #(
    parameter int unsigned DIV = 351
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] Last = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == Last);
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// 8N1 LSB-first UART receiver with 16x oversampling, single-entry output holding register,
// framing-error pulse and sticky overrun flag.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_HZ = DefClkHz,
    parameter int unsigned BAUD   = DefBaud,
    parameter int unsigned OVS    = DefOvs
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVS);

    logic       tick;
    logic [1:0] sync_q, sync_d;
    logic       rx_s;

    rx_state_e  state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic [7:0] shift_q, shift_d;
    logic       commit_q, commit_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign sync_d = {sync_q[0], rx_in};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        scnt_d  = 4'd0;
                    end
                end
                StStart: begin
                    // Mid start bit: a line already back high was only a glitch.
                    if (scnt_q == 4'd7) begin
                        if (rx_s) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            scnt_d  = 4'd0;
                            bidx_d  = 3'd0;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
                StData: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bidx_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bidx_d = bidx_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        state_d     = StIdle;
                        commit_d    = rx_s;
                        frame_err_d = !rx_s;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // An ack landing on the commit cycle frees the slot, so the new byte replaces the old.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (commit_q) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            scnt_q      <= 4'd0;
            bidx_q      <= 3'd0;
            shift_q     <= 8'h00;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule
